fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; minimum 2.
REQ-002 SHALL have parameter DATA_W, default 64: beat data width.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per grant; minimum 1.
REQ-004 clk_i  input  1  the single clock; all flops rise-edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  NUM_REQ  per-requester beat valid.
REQ-007 req_last_i  input  NUM_REQ  per-requester last beat of burst.
REQ-008 req_data_i  input  NUM_REQ x DATA_W  per-requester beat data.
REQ-009 req_ready_o  output  NUM_REQ  per-requester beat accepted.
REQ-010 fifo_wvalid_o  output  1  write valid to the downstream FIFO write port.
REQ-011 fifo_wready_i  input  1  downstream FIFO not full.
REQ-012 fifo_wdata_o  output  DATA_W  muxed beat data.
REQ-013 fifo_wsrc_o  output  $clog2(NUM_REQ)  index of the current grantee.
REQ-014 busy_o  output  1  high while in BURST state.

Function
REQ-015 States SHALL be IDLE and BURST; regs: state_q, gnt_q, rr_ptr_q, beat_cnt_q (width $clog2(MAX_BURST+1)).
REQ-016 In IDLE the winner SHALL be the first asserted req_valid_i at index >= rr_ptr_q, wrapping at NUM_REQ-1 to 0; in BURST the winner SHALL be gnt_q.
REQ-017 fifo_wvalid_o SHALL equal req_valid_i[winner]; fifo_wdata_o = req_data_i[winner]; fifo_wsrc_o = winner; zero-cycle pass-through.
REQ-018 req_ready_o[winner] SHALL equal fifo_wready_i; all other req_ready_o bits SHALL be 0.
REQ-019 A beat transfers when fifo_wvalid_o && fifo_wready_i; beat_cnt_q increments per transfer.
REQ-020 End-of-burst SHALL occur on a transfer with req_last_i[winner]=1 or with beat_cnt_q+1 == MAX_BURST.
REQ-021 IDLE, no valid: SHALL stay IDLE, regs hold.
REQ-022 IDLE, winner valid, no transfer (backpressure): SHALL go BURST, gnt_q=winner, beat_cnt_q=0, so the grant stays stable while stalled.
REQ-023 IDLE, transfer, not end-of-burst: SHALL go BURST, gnt_q=winner, beat_cnt_q=1.
REQ-024 IDLE or BURST, end-of-burst transfer: SHALL go IDLE, beat_cnt_q=0, rr_ptr_q=winner+1 mod NUM_REQ.
REQ-025 BURST with req_valid_i[gnt_q]=0 (requester bubble): SHALL hold grant; other requesters SHALL NOT be served.
REQ-026 MAX_BURST=1: every transfer SHALL end the burst; the pointer rotates every beat.
REQ-027 The same requester SHALL NOT win two consecutive bursts while any other requester is valid at the IDLE decision.

Reset
REQ-028 On rst_ni low, asynchronously: state_q=IDLE, gnt_q=0, rr_ptr_q=0, beat_cnt_q=0.
REQ-029 During and immediately after reset: busy_o=0, fifo_wsrc_o reflects IDLE arbitration from rr_ptr_q=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no further beat forwarded from the old grantee unless it wins fresh arbitration.

Structure
REQ-031 The state enum SHALL live in shared package fifo_arb_pkg.
REQ-032 Find-first-from-pointer logic SHALL be sub-module rr_pick (inputs: request vector, pointer; outputs: index, found).
REQ-033 The block SHALL contain no data storage; it drives the write side of fifo_ctrl-based FIFOs directly.

Verification
REQ-034 NUM_REQ=4, MAX_BURST=16. Requesters 0 and 2 valid; bursts of 3 beats each; wready=1 -> order 0,0,0,2,2,2,0,...; rr_ptr_q=1 after the first burst, 3 after the second.
REQ-035 Requester 1 is sending a 5-beat burst; wready=0 during beat 2 for 4 cycles while requester 3 is valid -> fifo_wsrc_o stays 1, req_ready_o[3]=0, beats arrive in order.
REQ-036 Requester 0 sends 40 beats with no last -> grant releases after beats 16 and 32; requester 1, valid throughout, gets the grant between them.
REQ-037 Requester 2 drops valid for 3 cycles mid-burst while requester 0 is valid -> busy_o=1 throughout, no beat from requester 0 until requester 2's last.
REQ-038 Assert rst_ni low at beat 2 of a 4-beat burst from requester 3 -> next cycle state IDLE, busy_o=0, rr_ptr_q=0; requester 0, if valid, wins.
REQ-039 Random valid/last/wready for 10k cycles -> scoreboard shows no beat loss or duplication, no interleaving within a burst, and no burst exceeds 16 beats.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin find-first: lowest request index at or after ptr, wrapping at N-1.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the farthest offset down so the closest hit to ptr is kept last
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = req[(int'(ptr) + i) % N] ? W'((int'(ptr) + i) % N) : idx;
      found = found | req[(int'(ptr) + i) % N];
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-aware round-robin arbiter feeding one FIFO write port; grant is held
// across stalls and requester bubbles until last beat or the burst cap.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ-1:0]                req_last_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              fifo_wvalid_o,
  input  logic                              fifo_wready_i,
  output logic [DATA_W-1:0]                 fifo_wdata_o,
  output logic [$clog2(NUM_REQ)-1:0]        fifo_wsrc_o,
  output logic                              busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_nxt_s;
  logic [IDX_W-1:0]  gnt_q, gnt_nxt_s;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_nxt_s;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_nxt_s;

  logic [IDX_W-1:0]  pick_idx_s;
  logic              pick_found_s;
  logic [IDX_W-1:0]  winner_s;
  logic [IDX_W-1:0]  ptr_after_s;
  logic              xfer_s;
  logic              eob_s;

  rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Winner selection and transfer / end-of-burst detection
  always_comb begin
    winner_s    = (state_q == BURST) ? gnt_q : pick_idx_s;
    xfer_s      = req_valid_i[winner_s] & fifo_wready_i;
    eob_s       = xfer_s & (req_last_i[winner_s] |
                            (beat_cnt_q == CNT_W'(MAX_BURST - 1)));
    ptr_after_s = (winner_s == IDX_W'(NUM_REQ - 1)) ? '0 : winner_s + IDX_W'(1);
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_nxt_s;
      gnt_q      <= gnt_nxt_s;
      rr_ptr_q   <= rr_ptr_nxt_s;
      beat_cnt_q <= beat_cnt_nxt_s;
    end
  end

  // Next-state logic; a stalled first beat still locks the grant (count 0)
  always_comb begin
    state_nxt_s    = state_q;
    gnt_nxt_s      = gnt_q;
    rr_ptr_nxt_s   = rr_ptr_q;
    beat_cnt_nxt_s = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s && eob_s) begin
          rr_ptr_nxt_s = ptr_after_s;
        end else if (pick_found_s) begin
          state_nxt_s    = BURST;
          gnt_nxt_s      = winner_s;
          beat_cnt_nxt_s = xfer_s ? CNT_W'(1) : CNT_W'(0);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (eob_s) begin
          state_nxt_s    = IDLE;
          beat_cnt_nxt_s = '0;
          rr_ptr_nxt_s   = ptr_after_s;
        end else if (xfer_s) begin
          beat_cnt_nxt_s = beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_nxt_s = beat_cnt_q;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        beat_cnt_nxt_s = '0;
      end
    endcase
  end

  // Output logic: zero-cycle pass-through of the winning requester
  always_comb begin
    fifo_wvalid_o          = req_valid_i[winner_s];
    fifo_wdata_o           = req_data_i[winner_s];
    fifo_wsrc_o            = winner_s;
    req_ready_o            = '0;
    req_ready_o[winner_s]  = fifo_wready_i;
    busy_o                 = (state_q == BURST);
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomised and directed bench for fifo_wr_arb against a behavioural arbiter model.
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int MB = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NR-1:0]         req_valid_i, req_last_i, req_ready_o;
  logic [NR-1:0][DW-1:0] req_data_i;
  logic                  fifo_wvalid_o, fifo_wready_i, busy_o;
  logic [DW-1:0]         fifo_wdata_o;
  logic [1:0]            fifo_wsrc_o;

  int n_checks = 0;
  int n_pass   = 0;
  int owner, cnt, ptr, fixed_len;
  int seq[NR];
  int rem[NR];

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_last_i    (req_last_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .fifo_wvalid_o (fifo_wvalid_o),
    .fifo_wready_i (fifo_wready_i),
    .fifo_wdata_o  (fifo_wdata_o),
    .fifo_wsrc_o   (fifo_wsrc_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [63:0] beat_data(input int i, input int s);
    return {i[7:0], 24'h0, s[31:0]};
  endfunction

  // Round-robin pick from the model pointer
  function automatic int exp_pick(input logic [3:0] v, output bit found);
    int w = 0;
    found = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (!found && v[(ptr + k) % NR]) begin
        w = (ptr + k) % NR;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  task automatic run_cycle(input logic [3:0] v, input logic wr, input logic [3:0] lforce,
                           input bit use_rem, output logic [1:0] src_seen, output logic busy_seen);
    logic [3:0] l;
    logic [3:0] one = 4'b0001;
    int w;
    bit found, xfer, eob;
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) begin
      l[i] = use_rem ? (rem[i] == 1) : lforce[i];
      req_data_i[i] = beat_data(i, seq[i]);
    end
    req_valid_i   = v;
    req_last_i    = l;
    fifo_wready_i = wr;
    #1;
    if (owner >= 0) begin
      w = owner;
      found = 1'b1;
    end else begin
      w = exp_pick(v, found);
    end
    check_val("busy", 64'(busy_o), 64'(owner >= 0));
    check_val("wvalid", 64'(fifo_wvalid_o), 64'(found && v[w]));
    if (found) begin
      check_val("wsrc", 64'(fifo_wsrc_o), 64'(w));
      check_val("ready", 64'(req_ready_o), wr ? 64'(one << w) : 64'(0));
      if (v[w]) check_val("wdata", fifo_wdata_o, beat_data(w, seq[w]));
    end
    src_seen  = fifo_wsrc_o;
    busy_seen = busy_o;
    xfer = found && v[w] && wr;
    eob  = xfer && (l[w] || (cnt + 1 == MB));
    @(posedge clk_i);
    if (xfer) begin
      seq[w]++;
      rem[w]--;
      if (rem[w] <= 0) rem[w] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 20));
    end
    if (eob) begin
      owner = -1;
      cnt   = 0;
      ptr   = (w + 1) % NR;
    end else if (found) begin
      owner = w;
      cnt   = cnt + (xfer ? 1 : 0);
    end
  endtask

  task automatic do_reset(input logic [3:0] v, input logic [1:0] exp_src);
    @(negedge clk_i);
    rst_ni        = 1'b0;
    req_valid_i   = v;
    req_last_i    = '0;
    fifo_wready_i = 1'b0;
    #1;
    check_val("rst_busy", 64'(busy_o), 64'(0));
    check_val("rst_wsrc", 64'(fifo_wsrc_o), 64'(exp_src));
    check_val("rst_wvalid", 64'(fifo_wvalid_o), 64'(v != 4'b0000));
    @(posedge clk_i);
    owner = -1;
    cnt   = 0;
    ptr   = 0;
    @(negedge clk_i);
    req_valid_i = '0;
    rst_ni      = 1'b1;
  endtask

  initial begin
    logic [1:0] s;
    logic       b;
    logic [8:0] stall_pat = 9'b111100001;
    logic [3:0] v37[7] = '{4'b0101, 4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0101};
    rst_ni = 1'b0;
    req_valid_i = '0;
    req_last_i = '0;
    req_data_i = '0;
    fifo_wready_i = 1'b0;
    owner = -1; cnt = 0; ptr = 0; fixed_len = 3;
    for (int i = 0; i < NR; i++) begin
      seq[i] = 0;
      rem[i] = 3;
    end
    // Reset view: IDLE arbitration from pointer 0
    do_reset(4'b1010, 2'd1);

    // Requesters 0 and 2, 3-beat bursts, alternate
    for (int i = 0; i < 12; i++) begin
      run_cycle(4'b0101, 1'b1, 4'b0000, 1'b1, s, b);
      check_val("rr_order", 64'(s), ((i / 3) % 2 == 1) ? 64'(2) : 64'(0));
    end

    // Requester 1 stalled on its second beat while requester 3 waits
    do_reset(4'b0000, 2'd0);
    fixed_len = 5;
    rem[1] = 5;
    for (int i = 0; i < 9; i++) begin
      run_cycle(4'b1010, stall_pat[i], 4'b0000, 1'b1, s, b);
      check_val("stall_hold", 64'(s), 64'(1));
    end

    // Burst cap: requester 0 without last, requester 1 slots in at the caps
    for (int i = 0; i < 34; i++) begin
      run_cycle(4'b0011, 1'b1, 4'b0010, 1'b0, s, b);
      check_val("cap_src", 64'(s), (i == 16 || i == 33) ? 64'(1) : 64'(0));
    end

    // Requester 2 bubbles mid-burst; requester 0 must not be served
    fixed_len = 4;
    rem[2] = 4;
    for (int i = 0; i < 7; i++) begin
      run_cycle(v37[i], 1'b1, 4'b0000, 1'b1, s, b);
      check_val("bubble_src", 64'(s), 64'(2));
      if (i > 0) check_val("bubble_busy", 64'(b), 64'(1));
    end

    // Reset mid-burst from requester 3; requester 0 then wins
    for (int i = 0; i < 2; i++) begin
      run_cycle(4'b1000, 1'b1, 4'b0000, 1'b0, s, b);
      check_val("pre_rst_src", 64'(s), 64'(3));
    end
    do_reset(4'b1001, 2'd0);

    // Random traffic
    fixed_len = 0;
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] v;
      for (int i = 0; i < NR; i++) v[i] = ($urandom_range(0, 3) != 0);
      run_cycle(v, ($urandom_range(0, 3) != 0), 4'b0000, 1'b1, s, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
